eth_udp_parse_ctrl: RTL and testbench
=====================================

ETH_UDP_PARSE_CTRL -- requirements
Module: eth_udp_parse_ctrl

Interface
REQ-001 Parameter ETH_TYPE, default 16'h0800, required Ethernet type.
REQ-002 Parameter IP_PROTO, default 8'h11, required IP protocol (UDP).
REQ-003 Parameter UDP_DST_PORT, default 16'd26400, accepted UDP destination port.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rstN  input  1  asynchronous, active-low reset.
REQ-006 dataValid  input  1  byte qualifier; a frame is one contiguous run of dataValid high, any low cycle ends it.
REQ-007 data  input  8  frame byte, Ethernet header first, MSB-first fields.
REQ-008 msgValid  output  1  ITCH message byte valid.
REQ-009 msgData  output  8  ITCH message byte.
REQ-010 msgStart  output  1  high with first byte of each message.
REQ-011 msgEnd  output  1  high with last byte of each message.
REQ-012 frameDone  output  1  one-cycle pulse: frame fully parsed, all messages delivered.
REQ-013 frameDrop  output  1  one-cycle pulse: frame rejected by a header check.
REQ-014 frameErr  output  1  one-cycle pulse: frame truncated before all messages delivered.
REQ-015 seqNum  output  64  MoldUDP64 sequence number of the current frame, held until the next MOLD header completes.
REQ-016 dropCnt  output  16  count of frameDrop plus frameErr pulses, saturating at 16'hFFFF.

Function
REQ-017 States: IDLE, ETH, IP, UDP, MOLD, MSG_LEN, MSG, TAIL, DROP; one 5-bit byte counter byteCnt, reloaded to 0 on every state entry.
REQ-018 IDLE: the first dataValid byte enters ETH as byte 0; ETH 14 bytes, IP 20, UDP 8, MOLD 22, MSG_LEN 2; advance on the cycle the last byte is accepted.
REQ-019 ETH check: bytes 12-13 equal ETH_TYPE, else DROP.
REQ-020 IP checks: byte 0 equals 8'h45 and byte 9 equals IP_PROTO, else DROP; no IP options supported.
REQ-021 UDP check: bytes 2-3 equal UDP_DST_PORT, else DROP.
REQ-022 Mismatch is detected on the last byte of the checked field; DROP is entered on the next edge and frameDrop pulses once.
REQ-023 MOLD: bytes 10-17 captured into seqNum, bytes 18-19 into a 16-bit msgRemain, bytes 20-21 into a 16-bit msgLen (first message length).
REQ-024 After MOLD: msgRemain 0 -> TAIL; else msgLen 0 -> decrement msgRemain and go to MSG_LEN (or TAIL if it reaches 0); else MSG.
REQ-025 MSG: forward msgLen bytes; msgData/msgValid registered, exactly 1 cycle after the input byte.
REQ-026 On the last message byte msgRemain decrements; nonzero -> MSG_LEN, zero -> TAIL.
REQ-027 MSG_LEN: 2 bytes form msgLen, same zero-length and msgRemain rules as REQ-024.
REQ-028 TAIL and DROP discard all bytes (trailing padding, FCS) until dataValid low, then IDLE.
REQ-029 frameDone pulses on the cycle after dataValid falls in TAIL.
REQ-030 dataValid low in ETH, IP, UDP, MOLD, MSG_LEN or MSG: IDLE next edge, frameErr pulses, dropCnt increments; a message cut mid-stream produces no msgEnd.
REQ-031 dataValid low in IDLE holds IDLE; gaps inside a frame are not supported.
REQ-032 msgStart and msgEnd are both high for a 1-byte message.
REQ-033 frameDrop and frameErr never pulse for the same frame; dropCnt increments once per rejected or truncated frame.

Reset
REQ-034 rstN low asynchronously forces IDLE, byteCnt 0, msgRemain 0, msgLen 0, seqNum 0, dropCnt 0 and all pulse and valid outputs 0.
REQ-035 After rstN deasserts mid-frame, remaining bytes of that frame are parsed as a new frame starting in ETH.

Verification
REQ-036 Valid frame, ethType 0x0800, proto 0x11, port 26400, msgCnt 1, moldLen 36, one 36-byte add order -> 36 msgValid bytes matching input, msgStart on byte 0, msgEnd on byte 35, frameDone 1 pulse, dropCnt 0.
REQ-037 Same frame with ethType 0x86DD -> no msgValid, frameDrop 1 pulse, dropCnt 1, next valid frame parsed normally.
REQ-038 msgCnt 2, lengths 36 and 25 -> 61 msgValid bytes, two msgStart/msgEnd pairs, seqNum equals header bytes 10-17.
REQ-039 msgCnt 0 heartbeat followed by 4 FCS bytes -> no msgValid, frameDone 1 pulse.
REQ-040 dataValid dropped after message byte 10 of 36 -> frameErr 1 pulse, no msgEnd, dropCnt 1, state IDLE.
REQ-041 rstN asserted during MSG -> all outputs 0 immediately; following valid frame produces correct output.

Source files
------------

// File: rtl/eth_udp_parse_ctrl_if.sv
// Byte-stream input and ITCH message output bundle for the UDP/MoldUDP64 parser.
// The parser takes the slave modport; the stimulus side takes the master modport.
interface eth_udp_parse_ctrl_if;
   logic        dataValid;
   logic [7:0]  data;
   logic        msgValid;
   logic [7:0]  msgData;
   logic        msgStart;
   logic        msgEnd;
   logic        frameDone;
   logic        frameDrop;
   logic        frameErr;
   logic [63:0] seqNum;
   logic [15:0] dropCnt;

   modport slave (
      input  dataValid, data,
      output msgValid, msgData, msgStart, msgEnd,
      output frameDone, frameDrop, frameErr, seqNum, dropCnt
   );

   modport master (
      output dataValid, data,
      input  msgValid, msgData, msgStart, msgEnd,
      input  frameDone, frameDrop, frameErr, seqNum, dropCnt
   );
endinterface

// File: rtl/eth_udp_parse_ctrl.sv
// Ethernet/IPv4/UDP/MoldUDP64 receive parser: checks the headers, then streams the
// ITCH message bytes with start/end framing, registered one cycle after the input byte.
module eth_udp_parse_ctrl #(
   parameter logic [15:0] ETH_TYPE     = 16'h0800,
   parameter logic [7:0]  IP_PROTO     = 8'h11,
   parameter logic [15:0] UDP_DST_PORT = 16'd26400
) (
   input  logic                clk,
   input  logic                rstN,
   eth_udp_parse_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_ETH, S_IP, S_UDP, S_MOLD, S_MSG_LEN, S_MSG, S_TAIL, S_DROP
   } state_t;

   state_t      r_state, w_nxt;
   logic [4:0]  r_byteCnt;
   logic [15:0] r_msgRemain, r_msgLen;
   logic [63:0] r_seqShift, r_seqNum;
   logic        r_hiOk;
   logic        r_msgValid, r_msgStart, r_msgEnd;
   logic [7:0]  r_msgData;
   logic        r_frameDone, r_frameDrop, r_frameErr;
   logic [15:0] r_dropCnt;

   logic        w_drop, w_err, w_done, w_fwd, w_decide, w_remDecEn, w_cntClr;
   logic [15:0] w_newLen, w_remDec;
   logic        w_dv;
   logic [7:0]  w_d;

   assign w_dv     = bus.dataValid;
   assign w_d      = bus.data;
   assign w_newLen = {r_msgLen[7:0], w_d};
   assign w_remDec = r_msgRemain - 16'd1;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt      = r_state;
      w_drop     = 1'b0;
      w_err      = 1'b0;
      w_done     = 1'b0;
      w_fwd      = 1'b0;
      w_decide   = 1'b0;
      w_remDecEn = 1'b0;
      case (r_state)
         S_IDLE: if (w_dv) w_nxt = S_ETH;
         S_ETH: begin
            if (!w_dv) begin
               w_nxt = S_IDLE; w_err = 1'b1;
            end else if (r_byteCnt == 5'd13) begin
               if (r_hiOk && w_d == ETH_TYPE[7:0]) w_nxt = S_IP;
               else begin w_nxt = S_DROP; w_drop = 1'b1; end
            end
         end
         S_IP: begin
            if (!w_dv) begin
               w_nxt = S_IDLE; w_err = 1'b1;
            end else if ((r_byteCnt == 5'd0 && w_d != 8'h45) ||
                         (r_byteCnt == 5'd9 && w_d != IP_PROTO)) begin
               w_nxt = S_DROP; w_drop = 1'b1;
            end else if (r_byteCnt == 5'd19) begin
               w_nxt = S_UDP;
            end
         end
         S_UDP: begin
            if (!w_dv) begin
               w_nxt = S_IDLE; w_err = 1'b1;
            end else if (r_byteCnt == 5'd3 && !(r_hiOk && w_d == UDP_DST_PORT[7:0])) begin
               w_nxt = S_DROP; w_drop = 1'b1;
            end else if (r_byteCnt == 5'd7) begin
               w_nxt = S_MOLD;
            end
         end
         // Both headers end with a 16-bit length: a zero length consumes one message slot
         // without entering MSG, so the next length field follows immediately.
         S_MOLD, S_MSG_LEN: begin
            if (!w_dv) begin
               w_nxt = S_IDLE; w_err = 1'b1;
            end else if (r_byteCnt == ((r_state == S_MOLD) ? 5'd21 : 5'd1)) begin
               w_decide = 1'b1;
               if (r_msgRemain == 16'd0) begin
                  w_nxt = S_TAIL;
               end else if (w_newLen == 16'd0) begin
                  w_remDecEn = 1'b1;
                  w_nxt      = (w_remDec == 16'd0) ? S_TAIL : S_MSG_LEN;
               end else begin
                  w_nxt = S_MSG;
               end
            end
         end
         S_MSG: begin
            if (!w_dv) begin
               w_nxt = S_IDLE; w_err = 1'b1;
            end else begin
               w_fwd = 1'b1;
               if (r_msgLen == 16'd1) begin
                  w_remDecEn = 1'b1;
                  w_nxt      = (w_remDec == 16'd0) ? S_TAIL : S_MSG_LEN;
               end
            end
         end
         S_TAIL: if (!w_dv) begin w_nxt = S_IDLE; w_done = 1'b1; end
         S_DROP: if (!w_dv) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // A decision also re-enters MSG_LEN on back-to-back zero-length messages.
   assign w_cntClr = (w_nxt != r_state) || w_decide;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_byteCnt   <= 5'd0;
         r_msgRemain <= 16'd0;
         r_msgLen    <= 16'd0;
         r_seqShift  <= 64'd0;
         r_seqNum    <= 64'd0;
         r_hiOk      <= 1'b0;
         r_msgValid  <= 1'b0;
         r_msgStart  <= 1'b0;
         r_msgEnd    <= 1'b0;
         r_msgData   <= 8'd0;
         r_frameDone <= 1'b0;
         r_frameDrop <= 1'b0;
         r_frameErr  <= 1'b0;
         r_dropCnt   <= 16'd0;
      end else begin
         r_msgValid  <= w_fwd;
         r_msgStart  <= w_fwd && (r_byteCnt == 5'd0);
         r_msgEnd    <= w_fwd && (r_msgLen == 16'd1);
         if (w_fwd) r_msgData <= w_d;
         r_frameDone <= w_done;
         r_frameDrop <= w_drop;
         r_frameErr  <= w_err;
         if ((w_drop || w_err) && r_dropCnt != 16'hFFFF) r_dropCnt <= r_dropCnt + 16'd1;

         // The IDLE byte is already ETH byte 0; saturation keeps msgStart exact in long messages.
         if (w_cntClr)                  r_byteCnt <= (r_state == S_IDLE) ? 5'd1 : 5'd0;
         else if (r_byteCnt != 5'd31)   r_byteCnt <= r_byteCnt + 5'd1;

         if (w_dv) begin
            case (r_state)
               S_ETH: if (r_byteCnt == 5'd12) r_hiOk <= (w_d == ETH_TYPE[15:8]);
               S_UDP: if (r_byteCnt == 5'd2)  r_hiOk <= (w_d == UDP_DST_PORT[15:8]);
               S_MOLD: begin
                  if (r_byteCnt >= 5'd10 && r_byteCnt <= 5'd17)
                     r_seqShift <= {r_seqShift[55:0], w_d};
                  if (r_byteCnt == 5'd18 || r_byteCnt == 5'd19)
                     r_msgRemain <= {r_msgRemain[7:0], w_d};
                  if (r_byteCnt == 5'd20) r_msgLen <= {8'h00, w_d};
                  if (r_byteCnt == 5'd21) r_seqNum <= r_seqShift;
               end
               S_MSG_LEN: if (r_byteCnt == 5'd0) r_msgLen <= {8'h00, w_d};
               S_MSG:     r_msgLen <= r_msgLen - 16'd1;
               default: ;
            endcase
            if (w_decide)   r_msgLen    <= w_newLen;
            if (w_remDecEn) r_msgRemain <= w_remDec;
         end
      end
   end

   assign bus.msgValid  = r_msgValid;
   assign bus.msgData   = r_msgData;
   assign bus.msgStart  = r_msgStart;
   assign bus.msgEnd    = r_msgEnd;
   assign bus.frameDone = r_frameDone;
   assign bus.frameDrop = r_frameDrop;
   assign bus.frameErr  = r_frameErr;
   assign bus.seqNum    = r_seqNum;
   assign bus.dropCnt   = r_dropCnt;

endmodule

// File: tb/tb_eth_udp_parse_ctrl.sv
// Bench for eth_udp_parse_ctrl: byte-offset frame model predicts every output per cycle,
// plus literal pins on message counts, seqNum and dropCnt after each directed frame.
module tb_eth_udp_parse_ctrl;
   localparam int MAXC = 4096;
   localparam logic [15:0] ETH_T = 16'h0800;
   localparam logic [7:0]  PROTO = 8'h11;
   localparam logic [15:0] PORT  = 16'd26400;

   logic clk, rstN;
   eth_udp_parse_ctrl_if bus();

   eth_udp_parse_ctrl #(.ETH_TYPE(ETH_T), .IP_PROTO(PROTO), .UDP_DST_PORT(PORT)) dut (
      .clk(clk), .rstN(rstN), .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0, nfail = 0;
   bit chk_en = 0;
   int nv, ns, ne, nd, ndr, ner;

   logic [7:0]  fb [0:511];
   int          fl;

   bit          exp_v    [MAXC];
   logic [7:0]  exp_d    [MAXC];
   bit          exp_s    [MAXC];
   bit          exp_e    [MAXC];
   bit          exp_done [MAXC];
   bit          exp_drop [MAXC];
   bit          exp_err  [MAXC];
   logic [63:0] exp_seq  [MAXC];
   logic [15:0] exp_dc   [MAXC];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic bump_dc(input int i);
      logic [15:0] v;
      if (i >= MAXC) return;
      v = exp_dc[i];
      if (v != 16'hFFFF) v = v + 16'd1;
      for (int k = i; k < MAXC; k++) exp_dc[k] = v;
   endtask

   task automatic mark_err(input int i);
      if (i < MAXC) exp_err[i] = 1'b1;
      bump_dc(i);
   endtask

   task automatic mark_drop(input int i);
      if (i < MAXC) exp_drop[i] = 1'b1;
      bump_dc(i);
   endtask

   // Walks the frame by absolute byte offset; output for byte k is expected at edge E+k.
   task automatic model_frame(input int E, input int n);
      int p, rem, ln;
      logic [63:0] sq;
      if (n <= 13) begin mark_err(E + n); return; end
      if ({fb[12], fb[13]} != ETH_T) begin mark_drop(E + 13); return; end
      if (n <= 14) begin mark_err(E + n); return; end
      if (fb[14] != 8'h45) begin mark_drop(E + 14); return; end
      if (n <= 23) begin mark_err(E + n); return; end
      if (fb[23] != PROTO) begin mark_drop(E + 23); return; end
      if (n <= 37) begin mark_err(E + n); return; end
      if ({fb[36], fb[37]} != PORT) begin mark_drop(E + 37); return; end
      if (n <= 63) begin mark_err(E + n); return; end
      sq = 64'd0;
      for (int i = 0; i < 8; i++) sq = {sq[55:0], fb[52 + i]};
      for (int k = E + 63; k < MAXC; k++) exp_seq[k] = sq;
      rem = int'({fb[60], fb[61]});
      p = 62;
      while (rem > 0) begin
         if (n <= p + 1) begin mark_err(E + n); return; end
         ln = int'({fb[p], fb[p + 1]});
         p += 2;
         rem--;
         for (int j = 0; j < ln; j++) begin
            if (n <= p) begin mark_err(E + n); return; end
            if (E + p < MAXC) begin
               exp_v[E + p] = 1'b1; exp_d[E + p] = fb[p];
               exp_s[E + p] = (j == 0); exp_e[E + p] = (j == ln - 1);
            end
            p++;
         end
      end
      if (E + n < MAXC) exp_done[E + n] = 1'b1;
   endtask

   task automatic model_reset(input int i);
      for (int k = i; k < MAXC; k++) begin
         exp_v[k] = 0; exp_s[k] = 0; exp_e[k] = 0; exp_done[k] = 0;
         exp_drop[k] = 0; exp_err[k] = 0; exp_seq[k] = 64'd0; exp_dc[k] = 16'd0;
      end
   endtask

   task automatic build(input logic [15:0] et, input logic [7:0] pr, input logic [15:0] pt,
                        input logic [63:0] sq, input int nmsg, input int l0, input int l1,
                        input int l2, input int pad);
      int lens [3];
      lens[0] = l0; lens[1] = l1; lens[2] = l2;
      for (int i = 0; i < 42; i++) fb[i] = 8'(i * 3 + 1);
      fb[12] = et[15:8]; fb[13] = et[7:0];
      fb[14] = 8'h45;    fb[23] = pr;
      fb[36] = pt[15:8]; fb[37] = pt[7:0];
      for (int i = 42; i < 52; i++) fb[i] = 8'h5A;
      for (int i = 0; i < 8; i++) fb[52 + i] = sq[63 - 8 * i -: 8];
      fb[60] = 8'(nmsg >> 8); fb[61] = 8'(nmsg);
      fl = 62;
      for (int m = 0; m < nmsg; m++) begin
         fb[fl] = 8'(lens[m] >> 8); fb[fl + 1] = 8'(lens[m]);
         fl += 2;
         for (int j = 0; j < lens[m]; j++) begin fb[fl] = 8'(m * 40 + j + 7); fl++; end
      end
      for (int i = 0; i < pad; i++) begin fb[fl] = 8'(8'hF0 + i); fl++; end
   endtask

   task automatic send(input int n, input bit rst_after);
      int E;
      @(negedge clk);
      E = cyc + 1;
      model_frame(E, n);
      bus.dataValid = 1'b1; bus.data = fb[0];
      for (int k = 1; k < n; k++) begin @(negedge clk); bus.data = fb[k]; end
      @(negedge clk);
      if (rst_after) begin
         #2;
         rstN = 1'b0; bus.dataValid = 1'b0;
         model_reset(E + n);
         #1;
         chk("rst_msgValid",  64'(bus.msgValid),  64'd0);
         chk("rst_msgStart",  64'(bus.msgStart),  64'd0);
         chk("rst_dropCnt",   64'(bus.dropCnt),   64'd0);
         chk("rst_seqNum",    bus.seqNum,         64'd0);
         repeat (2) @(negedge clk);
         rstN = 1'b1;
      end else begin
         bus.dataValid = 1'b0;
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      nv = 0; ns = 0; ne = 0; nd = 0; ndr = 0; ner = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         chk("msgValid", 64'(bus.msgValid), 64'(exp_v[cyc]));
         if (exp_v[cyc]) begin
            chk("msgData",  64'(bus.msgData),  64'(exp_d[cyc]));
            chk("msgStart", 64'(bus.msgStart), 64'(exp_s[cyc]));
            chk("msgEnd",   64'(bus.msgEnd),   64'(exp_e[cyc]));
         end
         chk("frameDone", 64'(bus.frameDone), 64'(exp_done[cyc]));
         chk("frameDrop", 64'(bus.frameDrop), 64'(exp_drop[cyc]));
         chk("frameErr",  64'(bus.frameErr),  64'(exp_err[cyc]));
         chk("seqNum",    bus.seqNum,         exp_seq[cyc]);
         chk("dropCnt",   64'(bus.dropCnt),   64'(exp_dc[cyc]));
         nv  += int'(bus.msgValid);
         ns  += int'(bus.msgStart);
         ne  += int'(bus.msgEnd);
         nd  += int'(bus.frameDone);
         ndr += int'(bus.frameDrop);
         ner += int'(bus.frameErr);
      end
   end

   initial begin
      for (int k = 0; k < MAXC; k++) begin
         exp_v[k] = 0; exp_d[k] = 8'd0; exp_s[k] = 0; exp_e[k] = 0; exp_done[k] = 0;
         exp_drop[k] = 0; exp_err[k] = 0; exp_seq[k] = 64'd0; exp_dc[k] = 16'd0;
      end
      clr_cnt();
      rstN = 1'b0; bus.dataValid = 1'b0; bus.data = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_msgValid",  64'(bus.msgValid),  64'd0);
      chk("reset_frameDone", 64'(bus.frameDone), 64'd0);
      chk("reset_seqNum",    bus.seqNum,         64'd0);
      chk("reset_dropCnt",   64'(bus.dropCnt),   64'd0);
      rstN = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // single 36-byte add order plus FCS
      build(ETH_T, PROTO, PORT, 64'h0000_0000_0000_1001, 1, 36, 0, 0, 4);
      send(fl, 0);
      chk("t1_nvalid", 64'(nv), 64'd36);
      chk("t1_nstart", 64'(ns), 64'd1);
      chk("t1_nend",   64'(ne), 64'd1);
      chk("t1_ndone",  64'(nd), 64'd1);
      chk("t1_dropCnt", 64'(bus.dropCnt), 64'd0);
      chk("t1_seqNum", bus.seqNum, 64'h0000_0000_0000_1001);
      clr_cnt();

      // IPv6 ethertype rejected, then a good frame still parses
      build(16'h86DD, PROTO, PORT, 64'h2, 1, 36, 0, 0, 4);
      send(fl, 0);
      chk("t2_nvalid", 64'(nv), 64'd0);
      chk("t2_ndrop",  64'(ndr), 64'd1);
      chk("t2_dropCnt", 64'(bus.dropCnt), 64'd1);
      clr_cnt();
      build(ETH_T, PROTO, PORT, 64'h3, 1, 36, 0, 0, 4);
      send(fl, 0);
      chk("t3_nvalid", 64'(nv), 64'd36);
      chk("t3_ndone",  64'(nd), 64'd1);
      clr_cnt();

      // two messages
      build(ETH_T, PROTO, PORT, 64'h0123_4567_89AB_CDEF, 2, 36, 25, 0, 4);
      send(fl, 0);
      chk("t4_nvalid", 64'(nv), 64'd61);
      chk("t4_nstart", 64'(ns), 64'd2);
      chk("t4_nend",   64'(ne), 64'd2);
      chk("t4_seqNum", bus.seqNum, 64'h0123_4567_89AB_CDEF);
      clr_cnt();

      // heartbeat
      build(ETH_T, PROTO, PORT, 64'h5, 0, 0, 0, 0, 4);
      send(fl, 0);
      chk("t5_nvalid", 64'(nv), 64'd0);
      chk("t5_ndone",  64'(nd), 64'd1);
      clr_cnt();

      // truncated after message byte 10
      build(ETH_T, PROTO, PORT, 64'h6, 1, 36, 0, 0, 4);
      send(64 + 11, 0);
      chk("t6_nvalid", 64'(nv), 64'd11);
      chk("t6_nend",   64'(ne), 64'd0);
      chk("t6_nerr",   64'(ner), 64'd1);
      chk("t6_dropCnt", 64'(bus.dropCnt), 64'd2);
      clr_cnt();

      // zero-length, one-byte and five-byte messages
      build(ETH_T, PROTO, PORT, 64'h7, 3, 0, 1, 5, 2);
      send(fl, 0);
      chk("t7_nvalid", 64'(nv), 64'd6);
      chk("t7_nstart", 64'(ns), 64'd2);
      chk("t7_nend",   64'(ne), 64'd2);
      clr_cnt();

      // wrong protocol, wrong port, header truncation
      build(ETH_T, 8'h06, PORT, 64'h8, 1, 4, 0, 0, 0);
      send(fl, 0);
      build(ETH_T, PROTO, 16'd26401, 64'h9, 1, 4, 0, 0, 0);
      send(fl, 0);
      chk("t8_ndrop", 64'(ndr), 64'd2);
      build(ETH_T, PROTO, PORT, 64'hA, 1, 4, 0, 0, 0);
      send(20, 0);
      chk("t8_nerr", 64'(ner), 64'd1);
      chk("t8_dropCnt", 64'(bus.dropCnt), 64'd5);
      clr_cnt();

      // reset in the middle of a message, then a clean frame
      build(ETH_T, PROTO, PORT, 64'hB, 1, 36, 0, 0, 4);
      send(80, 1);
      clr_cnt();
      build(ETH_T, PROTO, PORT, 64'hC, 1, 36, 0, 0, 4);
      send(fl, 0);
      chk("t9_nvalid", 64'(nv), 64'd36);
      chk("t9_ndone",  64'(nd), 64'd1);
      chk("t9_dropCnt", 64'(bus.dropCnt), 64'd0);
      chk("t9_seqNum", bus.seqNum, 64'hC);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
